// File: rtl/i2s_tx_pkg.sv
// Shared types and defaults for the I2S transmit serializer.
package i2s_tx_pkg;

    localparam int DEF_SAMPLE_W  = 16;
    localparam int DEF_BCLK_HALF = 2;

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        LOAD,
        RUN
    } tx_state_t;

    // Slot whose falling-edge event fetches the next frame's word.
    function automatic int prefetch_slot(input int sample_w);
        return 2 * sample_w - 2;
    endfunction

endpackage

// File: rtl/i2s_bclk_gen.sv
// BCLK divider: toggles BCLK every BCLK_HALF cycles while running and flags the
// cycle whose closing edge drives BCLK from 1 to 0.
module i2s_bclk_gen
    import i2s_tx_pkg::*;
#(
    parameter int BCLK_HALF = DEF_BCLK_HALF
) (
    input  logic clk_500,
    input  logic reset,
    input  logic run,
    output logic bclk,
    output logic fall_next
);

    localparam int CNT_W = $clog2(BCLK_HALF);

    logic [CNT_W-1:0] div_cnt;
    logic             wrap;

    assign wrap      = run && (div_cnt == CNT_W'(BCLK_HALF - 1));
    assign fall_next = wrap && bclk;

    // Held at zero outside RUN so every frame sequence starts at slot 0 with BCLK low.
    always_ff @(posedge clk_500) begin
        if (reset || !run) begin
            div_cnt <= '0;
            bclk    <= 1'b0;
        end else if (wrap) begin
            div_cnt <= '0;
            bclk    <= ~bclk;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/i2s_tx_serializer.sv
// Drains the effect-chain output FIFO onto an I2S link: one FIFO word per frame,
// left channel in the upper half, MSB first with the I2S one-bit delay.
module i2s_tx_serializer
    import i2s_tx_pkg::*;
#(
    parameter int SAMPLE_W  = DEF_SAMPLE_W,
    parameter int BCLK_HALF = DEF_BCLK_HALF
) (
    input  logic                  clk_500,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [2*SAMPLE_W-1:0] fifo_q,
    input  logic                  fifo_rdempty,
    output logic                  fifo_rdreq,
    output logic                  i2s_bclk,
    output logic                  i2s_lrclk,
    output logic                  i2s_sdata,
    output logic                  underrun,
    input  logic                  underrun_clr,
    output logic                  frame_done
);

    localparam int              WORD_W = 2 * SAMPLE_W;
    localparam int              SLOT_W = $clog2(WORD_W);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(WORD_W - 1);
    localparam logic [SLOT_W-1:0] PF_SLOT   = SLOT_W'(prefetch_slot(SAMPLE_W));
    localparam logic [SLOT_W-1:0] RIGHT_SLOT = SLOT_W'(SAMPLE_W);

    tx_state_t         state;
    logic [SLOT_W-1:0] slot;
    logic [SLOT_W-1:0] next_slot;
    logic [WORD_W-1:0] shift_reg;
    logic [WORD_W-1:0] hold_reg;
    logic              cap_pending;
    logic              running;
    logic              fall_next;
    logic              underrun_set;

    assign running      = (state == RUN);
    assign next_slot    = (slot == LAST_SLOT) ? '0 : slot + 1'b1;
    assign underrun_set = running && fall_next && (next_slot == PF_SLOT) && fifo_rdempty;

    i2s_bclk_gen #(
        .BCLK_HALF(BCLK_HALF)
    ) u_bclk_gen (
        .clk_500  (clk_500),
        .reset    (reset),
        .run      (running),
        .bclk     (i2s_bclk),
        .fall_next(fall_next)
    );

    always_ff @(posedge clk_500) begin
        if (reset) begin
            state       <= IDLE;
            slot        <= '0;
            shift_reg   <= '0;
            hold_reg    <= '0;
            cap_pending <= 1'b0;
            fifo_rdreq  <= 1'b0;
            frame_done  <= 1'b0;
            i2s_lrclk   <= 1'b0;
            i2s_sdata   <= 1'b0;
        end else begin
            // NOTE: strobes default low here; the case below overrides them for one cycle.
            fifo_rdreq  <= 1'b0;
            frame_done  <= 1'b0;
            cap_pending <= fifo_rdreq && running;
            if (cap_pending) hold_reg <= fifo_q;

            case (state)
                IDLE: begin
                    if (enable && !fifo_rdempty) begin
                        state      <= PRIME;
                        fifo_rdreq <= 1'b1;
                    end
                end
                PRIME: state <= LOAD;
                LOAD: begin
                    state     <= RUN;
                    shift_reg <= fifo_q;
                    slot      <= '0;
                    i2s_lrclk <= 1'b0;
                    i2s_sdata <= 1'b0;
                end
                RUN: begin
                    if (fall_next) begin
                        slot      <= next_slot;
                        i2s_lrclk <= (next_slot >= RIGHT_SLOT);
                        // After WORD_W-1 shifts the MSB holds the old word's bit 0 for slot 0.
                        i2s_sdata <= shift_reg[WORD_W-1];
                        if (next_slot == PF_SLOT) begin
                            if (!fifo_rdempty) fifo_rdreq <= 1'b1;
                            else               hold_reg   <= '0;
                        end
                        if (next_slot == '0) begin
                            shift_reg  <= hold_reg;
                            frame_done <= 1'b1;
                            if (!enable) begin
                                state     <= IDLE;
                                i2s_lrclk <= 1'b0;
                                i2s_sdata <= 1'b0;
                            end
                        end else begin
                            shift_reg <= shift_reg << 1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_500) begin
        if (reset)             underrun <= 1'b0;
        else if (underrun_set) underrun <= 1'b1;
        else if (underrun_clr) underrun <= 1'b0;
    end

endmodule

// File: doc/i2s_tx_serializer.md
# i2s_tx_serializer

Drains the effect-chain output FIFO and serialises each 32-bit processed sample word onto a standard I2S link to the audio DAC. It generates BCLK and LRCLK from `clk_500` and issues FIFO read requests at a fixed point in each frame. It mutes and flags underruns when the FIFO runs dry. It sits directly downstream of the guitar-effect output FIFO, on the FIFO read port.

## Interface
Parameters:
- `SAMPLE_W`, 16: bits per channel. The FIFO word is 2*`SAMPLE_W` bits: left = upper half, right = lower half.
- `BCLK_HALF`, 2: `clk_500` cycles per BCLK half-period. Legal values are ≥2.

Ports:
- `clk_500`, in, 1: block clock.
- `reset`, in, 1: reset, synchronous, active-high; clock `clk_500`.
- `enable`, in, 1: run request.
- `fifo_q`, in, 2*`SAMPLE_W`: FIFO read data, valid the cycle after `fifo_rdreq`.
- `fifo_rdempty`, in, 1: FIFO empty.
- `fifo_rdreq`, out, 1: single-cycle read strobe.
- `i2s_bclk`, out, 1: bit clock.
- `i2s_lrclk`, out, 1: 0 = left, 1 = right.
- `i2s_sdata`, out, 1: serial data, MSB first.
- `underrun`, out, 1: sticky underrun flag.
- `underrun_clr`, in, 1: clears `underrun`.
- `frame_done`, out, 1: one-cycle pulse at each frame end.

## Operation
- Reset values: all outputs 0, FSM in IDLE, shift and holding registers 0.
- FSM states:
  - IDLE: entered from reset, or from a frame end while `enable`=0.
  - PRIME: entered from IDLE when `enable`=1 and `fifo_rdempty`=0. Pulses `fifo_rdreq` for one cycle.
  - LOAD: captures `fifo_q` into the shift register.
  - RUN: serialises frames continuously.
- IDLE with `enable`=1 and an empty FIFO: remain in IDLE. No underrun is flagged at startup.
- Divider: `div_cnt` counts 0..`BCLK_HALF`-1 in RUN. On wrap, BCLK toggles. A falling-edge event (BCLK 1→0, plus the first RUN cycle) advances `slot` through 0..2*`SAMPLE_W`-1.
- LRCLK is 0 for slots 0..`SAMPLE_W`-1 and 1 for the rest. It changes on the falling-edge event.
- SDATA uses the I2S one-bit delay:
  - Slot 0 carries bit 0 of the previous frame's word, or 0 for the first frame after IDLE.
  - Slot k≥1 carries word bit 2*`SAMPLE_W`-k.
  - SDATA changes only on falling-edge events.
- Prefetch: at the falling-edge event entering slot 2*`SAMPLE_W`-2:
  - FIFO not empty: assert `fifo_rdreq` for one cycle. Capture `fifo_q` into the holding register the next cycle.
  - FIFO empty: load 0 into the holding register (mute) and set `underrun`.
- Frame boundary: the falling-edge event where `slot` wraps 2*`SAMPLE_W`-1→0.
  - Move the holding register into the shift register.
  - Pulse `frame_done`.
  - If `enable`=0, go to IDLE; BCLK, LRCLK and SDATA become 0 in the same cycle.
- `enable` dropping mid-frame has no effect until the frame boundary. The current frame always completes.
- `underrun`: set by the empty-FIFO prefetch case. Cleared by `underrun_clr`. If set and clear occur in the same cycle, set wins.
- Reset asserted mid-frame returns the block to its reset values on the next edge. No partial `fifo_rdreq` is issued.

## Timing
- BCLK period = 2*`BCLK_HALF` cycles. Frame = 4*`SAMPLE_W`*`BCLK_HALF` cycles. Defaults give 4-cycle BCLK and 128-cycle frames.
- Startup, with IDLE, `enable`=1 and not empty at cycle n:
  - Cycle n: `fifo_rdreq`=1 (PRIME).
  - Cycle n+1: LOAD captures `fifo_q`.
  - Cycle n+2: first RUN cycle, slot 0, BCLK=0, LRCLK=0.
  - First BCLK rise at n+2+`BCLK_HALF`.
- Steady state: exactly one `fifo_rdreq` per frame, 2*`BCLK_HALF`*2 cycles before the frame boundary. The holding register is valid ≥2 cycles before it is used.
- `frame_done` is high in the cycle of the boundary event.

## Structure
- Package `i2s_tx_pkg`: FSM state enum (IDLE, PRIME, LOAD, RUN), default `SAMPLE_W`/`BCLK_HALF` constants, slot index of the prefetch.
- Sub-module `i2s_bclk_gen`: contains `div_cnt`, BCLK toggling and the falling-edge strobe. The top level holds the FSM, slot counter, shift/holding registers and underrun logic.

## Test plan
1. Reset, then hold reset for 10 cycles with `enable`=1 and the FIFO not empty → all outputs 0 and no `fifo_rdreq`.
2. Defaults, one word 0xA5A5_3C3C, `enable` dropped at the end of frame 1:
   - LRCLK is low for 64 cycles, then high for 64.
   - Slots 1..16 give 1010010110100101 (left MSB..LSB shifted by one slot). Slots 17..31 plus slot 0 of the next frame give 0x3C3C.
   - `frame_done` at cycle 128 after RUN entry, then IDLE.
3. Three back-to-back words 0x0001_8000, 0xFFFF_0000, 0x1234_5678 → one `fifo_rdreq` per frame at slot 30. The decoded channels match the words in order.
4. FIFO holds one word, `enable` held high:
   - Frame 2 is all zeros and `underrun`=1 from slot 30 of frame 1.
   - A later `underrun_clr` pulse clears it.
   - An `underrun_clr` coincident with a new underrun leaves `underrun`=1.
5. `enable` drops at slot 5 → the frame completes, `frame_done` pulses, the outputs go to 0, and no further reads occur.
6. `reset` asserted at slot 20 → all outputs are 0 next cycle. Restart yields a fresh PRIME/LOAD sequence.
